// File: rtl/sevenseg_scan.sv
// -----------------------------------------------------------------------------
// sevenseg_scan
//
// Time-multiplexed driver for an N-digit common-anode seven-segment display.
// A packed hex word and per-digit decimal points are captured into a shadow
// register on a load strobe. The display is then scanned one digit at a time.
// An optional all-off gap between digits suppresses ghosting.
//
// Scan timeline per digit: BLANK for BLANK_CYC cycles, then SHOW for CLK_DIV
// cycles. The anode and segment pins are registered from the current state,
// so they trail the state machine by one clock.
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   load        single-cycle strobe; captures data_in/dp_in into the shadow
//   data_in     hex nibbles, digit k = data_in[4k+3:4k], digit 0 rightmost
//   dp_in       decimal point per digit, 1 = lit
//   blank_mask  1 = force digit dark (sampled live, not shadowed)
//   lz_en       leading-zero suppression enable (sampled live)
//   segments    {dp,g,f,e,d,c,b,a}, registered, polarity set by SEG_ACT_LOW
//   anodes      digit enables, registered, polarity set by AN_ACT_LOW
//   digit_idx   index of the digit being shown, or about to be shown
//   frame_done  one-cycle pulse when the SHOW of the last digit ends
// -----------------------------------------------------------------------------
module sevenseg_scan #(
  parameter int N_DIGITS    = 8,
  parameter int CLK_DIV     = 50000,
  parameter int BLANK_CYC   = 2,
  parameter bit SEG_ACT_LOW = 1'b1,
  parameter bit AN_ACT_LOW  = 1'b1,
  // Derived width, exposed so the digit_idx port can be sized
  parameter int IDX_W       = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] data_in,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic [N_DIGITS-1:0]   blank_mask,
  input  logic                  lz_en,
  output logic [7:0]            segments,
  output logic [N_DIGITS-1:0]   anodes,
  output logic [IDX_W-1:0]      digit_idx,
  output logic                  frame_done
);

  // ---------------------------------------------------------------------------
  // Derived constants
  // ---------------------------------------------------------------------------
  // One counter serves both phases, so it must span the longer of the two.
  localparam int CNT_MAX = (CLK_DIV > BLANK_CYC) ? CLK_DIV : BLANK_CYC;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_DIGITS - 1);
  localparam bit               HAS_GAP    = (BLANK_CYC > 0);

  // "Off" levels on the pins for each polarity choice
  localparam logic [7:0]          SEG_OFF = SEG_ACT_LOW ? 8'hFF : 8'h00;
  localparam logic [N_DIGITS-1:0] AN_OFF  = AN_ACT_LOW ? {N_DIGITS{1'b1}} : {N_DIGITS{1'b0}};

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  // Without a gap there is no BLANK phase at all, including after reset.
  localparam state_t RST_STATE = HAS_GAP ? ST_BLANK : ST_SHOW;

  // ---------------------------------------------------------------------------
  // Hex to active-low segment pattern, bits {g,f,e,d,c,b,a}
  // ---------------------------------------------------------------------------
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0:    pat = 7'h40;
      4'h1:    pat = 7'h79;
      4'h2:    pat = 7'h24;
      4'h3:    pat = 7'h30;
      4'h4:    pat = 7'h19;
      4'h5:    pat = 7'h12;
      4'h6:    pat = 7'h02;
      4'h7:    pat = 7'h78;
      4'h8:    pat = 7'h00;
      4'h9:    pat = 7'h10;
      4'hA:    pat = 7'h08;
      4'hB:    pat = 7'h03;
      4'hC:    pat = 7'h46;
      4'hD:    pat = 7'h21;
      4'hE:    pat = 7'h06;
      default: pat = 7'h0E;
    endcase
    return pat;
  endfunction

  // ---------------------------------------------------------------------------
  // Shadow register
  // ---------------------------------------------------------------------------
  logic [4*N_DIGITS-1:0] shadow_data_reg;
  logic [N_DIGITS-1:0]   shadow_dp_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_data_reg <= '0;
      shadow_dp_reg   <= '0;
    end else if (load) begin
      shadow_data_reg <= data_in;
      shadow_dp_reg   <= dp_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-digit views of the shadow
  // ---------------------------------------------------------------------------
  logic [3:0]          nibbles [N_DIGITS];
  logic [N_DIGITS-1:0] upper_zero;   // upper_zero[k]: nibbles k..N-1 are all zero

  generate
    for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_digit
      assign nibbles[gi]    = shadow_data_reg[4*gi +: 4];
      assign upper_zero[gi] = (shadow_data_reg[4*N_DIGITS-1 : 4*gi] == '0);
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Scan state
  // ---------------------------------------------------------------------------
  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;

  // ---------------------------------------------------------------------------
  // Next pin values, derived from the current state and the live controls
  // ---------------------------------------------------------------------------
  logic [3:0]          cur_nib;
  logic                cur_dp;
  logic                cur_dark;
  logic [7:0]          seg_al;     // active-low pattern before polarity
  logic [N_DIGITS-1:0] an_onehot;
  logic [7:0]          seg_next;
  logic [N_DIGITS-1:0] an_next;

  assign cur_nib = nibbles[digit_idx];
  assign cur_dp  = shadow_dp_reg[digit_idx];

  // Digit 0 is never suppressed as a leading zero, so "0" still shows.
  assign cur_dark = blank_mask[digit_idx] ||
                    (lz_en && (digit_idx != '0) && upper_zero[digit_idx]);

  always_comb begin
    seg_next  = SEG_OFF;
    an_next   = AN_OFF;
    seg_al    = 8'hFF;
    an_onehot = '0;
    if (state_reg == ST_SHOW) begin
      an_onehot = {{(N_DIGITS-1){1'b0}}, 1'b1} << digit_idx;
      an_next   = AN_ACT_LOW ? ~an_onehot : an_onehot;
      // A dark digit keeps its anode driven but lights nothing, dp included.
      if (!cur_dark) begin
        seg_al = {~cur_dp, hex_to_seg(cur_nib)};
      end
      seg_next = SEG_ACT_LOW ? seg_al : ~seg_al;
    end
  end

  // ---------------------------------------------------------------------------
  // Scan FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= RST_STATE;
      cnt_reg    <= '0;
      digit_idx  <= '0;
      segments   <= SEG_OFF;
      anodes     <= AN_OFF;
      frame_done <= 1'b0;
    end else begin
      segments   <= seg_next;
      anodes     <= an_next;
      frame_done <= 1'b0;
      case (state_reg)
        ST_BLANK: begin
          if (cnt_reg == BLANK_LAST) begin
            cnt_reg   <= '0;
            state_reg <= ST_SHOW;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        ST_SHOW: begin
          if (cnt_reg == SHOW_LAST) begin
            cnt_reg    <= '0;
            digit_idx  <= (digit_idx == IDX_LAST) ? '0 : digit_idx + IDX_W'(1);
            state_reg  <= HAS_GAP ? ST_BLANK : ST_SHOW;
            frame_done <= (digit_idx == IDX_LAST);
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        default: begin
          cnt_reg   <= '0;
          state_reg <= RST_STATE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sevenseg_scan.sv
// -----------------------------------------------------------------------------
// tb_sevenseg_scan
//
// Two instances share stimulus: an active-low one with a one-cycle gap
// (N=4, CLK_DIV=4, BLANK_CYC=1) and an active-high one with no gap
// (N=4, CLK_DIV=4, BLANK_CYC=0). Expected pin values come from a timeline
// model: the number of clock edges since reset release gives the digit and
// phase by division, and the digit content comes from a table lookup.
// -----------------------------------------------------------------------------
module tb_sevenseg_scan;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load;
  logic [15:0] data_in;
  logic [3:0]  dp_in;
  logic [3:0]  blank_mask;
  logic        lz_en;

  logic [7:0]  lo_segments, hi_segments;
  logic [3:0]  lo_anodes,   hi_anodes;
  logic [1:0]  lo_idx,      hi_idx;
  logic        lo_fd,       hi_fd;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sevenseg_scan #(
    .N_DIGITS(4), .CLK_DIV(4), .BLANK_CYC(1), .SEG_ACT_LOW(1'b1), .AN_ACT_LOW(1'b1)
  ) u_lo (
    .clk(clk), .rst_n(rst_n), .load(load), .data_in(data_in), .dp_in(dp_in),
    .blank_mask(blank_mask), .lz_en(lz_en),
    .segments(lo_segments), .anodes(lo_anodes), .digit_idx(lo_idx), .frame_done(lo_fd)
  );

  sevenseg_scan #(
    .N_DIGITS(4), .CLK_DIV(4), .BLANK_CYC(0), .SEG_ACT_LOW(1'b0), .AN_ACT_LOW(1'b0)
  ) u_hi (
    .clk(clk), .rst_n(rst_n), .load(load), .data_in(data_in), .dp_in(dp_in),
    .blank_mask(blank_mask), .lz_en(lz_en),
    .segments(hi_segments), .anodes(hi_anodes), .digit_idx(hi_idx), .frame_done(hi_fd)
  );

  // Active-low patterns with dp off, indexed by hex value
  logic [7:0] hex_tbl [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  // ---------------------------------------------------------------------------
  // Reference state: edges since release, the shadow, and the values that the
  // most recent edge saw (which are what the pins now reflect).
  // ---------------------------------------------------------------------------
  int          k;
  logic [15:0] sh_data, pv_data;
  logic [3:0]  sh_dp, pv_dp, pv_mask;
  logic        pv_lz;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k       <= 0;
      sh_data <= '0;
      sh_dp   <= '0;
      pv_data <= '0;
      pv_dp   <= '0;
      pv_mask <= '0;
      pv_lz   <= 1'b0;
    end else begin
      k       <= k + 1;
      pv_data <= sh_data;
      pv_dp   <= sh_dp;
      pv_mask <= blank_mask;
      pv_lz   <= lz_en;
      if (load) begin
        sh_data <= data_in;
        sh_dp   <= dp_in;
      end
    end
  end

  function automatic void model_out(
    input  int          cdiv,
    input  int          bc,
    input  bit          sal,
    input  bit          aal,
    input  int          kk,
    input  logic [15:0] d16,
    input  logic [3:0]  dp4,
    input  logic [3:0]  m4,
    input  logic        lz,
    output logic [7:0]  seg,
    output logic [3:0]  an,
    output logic [1:0]  idx,
    output logic        fd
  );
    int per, c, d, p;
    logic [7:0] al;
    logic [3:0] oh;
    per = cdiv + bc;
    seg = sal ? 8'hFF : 8'h00;
    an  = aal ? 4'hF : 4'h0;
    idx = 2'd0;
    fd  = 1'b0;
    if (kk == 0) return;
    // The pins now show timeline cycle kk-1; digit_idx already shows cycle kk.
    c   = kk - 1;
    d   = (c / per) % 4;
    p   = c % per;
    idx = 2'((kk / per) % 4);
    if (p >= bc) begin
      oh = 4'(1 << d);
      an = aal ? ~oh : oh;
      if (m4[d] || (lz && d > 0 && (d16 >> (4 * d)) == 16'h0)) begin
        al = 8'hFF;
      end else begin
        al    = hex_tbl[(d16 >> (4 * d)) & 16'hF];
        al[7] = ~dp4[d];
      end
      seg = sal ? al : ~al;
      fd  = (d == 3) && (p == per - 1);
    end
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (k=%0d, t=%0t)", tag, got, exp, k, $time);
    end
  endtask

  task automatic check_all();
    logic [7:0] es;
    logic [3:0] ea;
    logic [1:0] ei;
    logic       ef;
    model_out(4, 1, 1'b1, 1'b1, k, pv_data, pv_dp, pv_mask, pv_lz, es, ea, ei, ef);
    check_val("lo_seg", 32'(lo_segments), 32'(es));
    check_val("lo_an",  32'(lo_anodes),   32'(ea));
    check_val("lo_idx", 32'(lo_idx),      32'(ei));
    check_val("lo_fd",  32'(lo_fd),       32'(ef));
    model_out(4, 0, 1'b0, 1'b0, k, pv_data, pv_dp, pv_mask, pv_lz, es, ea, ei, ef);
    check_val("hi_seg", 32'(hi_segments), 32'(es));
    check_val("hi_an",  32'(hi_anodes),   32'(ea));
    check_val("hi_idx", 32'(hi_idx),      32'(ei));
    check_val("hi_fd",  32'(hi_fd),       32'(ef));
  endtask

  // Drive inputs for one cycle, then check the pins on the following negedge.
  task automatic step(input logic ld, input logic [15:0] d, input logic [3:0] dp,
                      input logic [3:0] mask, input logic lz);
    load       = ld;
    data_in    = d;
    dp_in      = dp;
    blank_mask = mask;
    lz_en      = lz;
    if (ld)
      $display("load data=%h dp=%b mask=%b lz=%0d k=%0d", d, dp, mask, lz, k);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n, input logic [3:0] mask, input logic lz);
    for (int i = 0; i < n; i++) step(1'b0, data_in, dp_in, mask, lz);
  endtask

  initial begin
    logic [15:0] rd;
    logic        found;
    rst_n      = 1'b0;
    load       = 1'b0;
    data_in    = '0;
    dp_in      = '0;
    blank_mask = '0;
    lz_en      = 1'b0;

    // Reset held: pins at their off levels
    repeat (3) begin
      @(negedge clk);
      check_all();
    end
    rst_n = 1'b1;

    // Scan with an empty shadow
    idle(30, 4'b0000, 1'b0);

    // Mixed digits with one decimal point
    step(1'b1, 16'h9A3F, 4'b0100, 4'b0000, 1'b0);
    idle(45, 4'b0000, 1'b0);

    // Leading-zero suppression on, then off
    step(1'b1, 16'h0070, 4'b0000, 4'b0000, 1'b1);
    idle(25, 4'b0000, 1'b1);
    idle(25, 4'b0000, 1'b0);

    // Per-digit blanking
    step(1'b1, 16'h1234, 4'b0000, 4'b0010, 1'b0);
    idle(25, 4'b0010, 1'b0);
    idle(5, 4'b0000, 1'b0);

    // Active-high instance digit 0 = 8
    step(1'b1, 16'h0008, 4'b0000, 4'b0000, 1'b0);
    idle(20, 4'b0000, 1'b0);

    // Random traffic, including loads landing on digit transitions
    for (int i = 0; i < 400; i++) begin
      rd = 16'($urandom);
      case ($urandom_range(0, 3))
        0: rd = rd & 16'h00FF;
        1: rd = rd & 16'h000F;
        default: ;
      endcase
      step(($urandom_range(0, 7) == 0), rd, 4'($urandom),
           ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000,
           1'($urandom_range(0, 1)));
    end

    // Reset in the middle of digit 2 SHOW on the gapped instance
    step(1'b1, 16'hBEEF, 4'b1111, 4'b0000, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (((k / 5) % 4 == 2) && (k % 5 == 2)) found = 1'b1;
      else step(1'b0, data_in, dp_in, 4'b0000, 1'b0);
    end
    check_val("d2_wait", 32'(found), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_val("async_lo_an",  32'(lo_anodes),   32'h0000000F);
    check_val("async_lo_seg", 32'(lo_segments), 32'h000000FF);
    check_val("async_hi_an",  32'(hi_anodes),   32'h00000000);
    check_val("async_hi_seg", 32'(hi_segments), 32'h00000000);
    @(negedge clk);
    check_all();
    rst_n = 1'b1;
    // Shadow was cleared: every digit should now read 0
    idle(45, 4'b0000, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
